alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Port list (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  operation request, sampled on rising clk
- alu_ctl  in  4  operation code from the ALU control unit
- op_a  in  16  rs operand
- op_b  in  16  rt operand
- imm  in  16  sign-extended immediate
- shamt  in  4  shift amount
- busy  out  1  high while a multi-cycle shift is in progress
- done  out  1  one-cycle completion pulse
- result  out  16  registered result
- zero  out  1  result == 0
- branch_taken  out  1  branch/jump decision
- illegal  out  1  last accepted code was unsupported
REQ-003 Parameter: WIDTH, default 16, data width of op_a, op_b, imm and result.

Function
REQ-004 Code map:
- 1 add: a+b
- 2 or: a|b
- 3 slt: signed a<b
- 4 and: a&b
- 5 addi: a+imm
- 6 beq: a-b, taken if a==b
- 7 bne: a-b, taken if a!=b
- 8 jmp: imm, taken=1
- 9 lw: a+imm
- 10 slti: signed a<imm
- 11 sll: a<<shamt
- 12 srl: logical a>>shamt
- 13 sw: a+imm
- 14 xor: a^b
REQ-005 Codes 0 and 15 SHALL complete as single-cycle operations with result=0, branch_taken=0 and illegal=1. All other codes SHALL set illegal=0.
REQ-006 All arithmetic SHALL be WIDTH-bit with wrap-around and no overflow flag. slt and slti SHALL return 16'h0001 when true and 16'h0000 when false.
REQ-007 branch_taken SHALL be 0 for every code other than 6, 7 and 8.
REQ-008 The FSM SHALL have two states, IDLE and SHIFT. busy SHALL equal (state==SHIFT).
REQ-009 A request SHALL be accepted on a rising edge where start=1 and state is IDLE. start SHALL be ignored while busy=1.
REQ-010 Single-cycle ops (every code except 11/12, plus 11/12 with shamt=0): result, zero, branch_taken, illegal and done=1 SHALL be registered on the accept edge. Latency is 1 cycle.
REQ-011 For 11/12 with shamt=n>0:
- The accept edge SHALL load op_a into a shift register, load counter=n and enter SHIFT.
- Each subsequent edge SHALL shift by one bit and decrement the counter.
- The edge that brings the counter to 0 SHALL register result, set done=1 and return to IDLE.
- done is therefore seen n cycles after the accept edge.
REQ-012 During SHIFT, alu_ctl, op_a and shamt changes SHALL be ignored. The operands captured at the accept edge govern the operation.
REQ-013 done SHALL be high for exactly one cycle per accepted operation and low otherwise.
REQ-014 A new request SHALL be acceptable in the cycle done=1, since the block is in IDLE; back-to-back single-cycle ops give done=1 on consecutive cycles.
REQ-015 result, zero, branch_taken and illegal SHALL hold their values between completions. zero SHALL always equal (result==0).

Reset
REQ-016 When rst=1 at a rising edge:
- state SHALL go to IDLE.
- busy, done, branch_taken and illegal SHALL go to 0.
- result SHALL go to 0, and zero SHALL go to 1.
- The counter and shift register SHALL be cleared.
REQ-017 rst SHALL take priority over start. Reset during SHIFT SHALL abort the operation without asserting done.

Verification
REQ-018 rst=1 for 2 cycles, then rst=0 -> result=0, zero=1, busy=0, done=0, branch_taken=0, illegal=0.
REQ-019 start=1, alu_ctl=1, a=16'hFFFF, b=16'h0002 -> next cycle done=1, result=16'h0001, zero=0. Then start=1, alu_ctl=3, a=16'hFFFF, b=16'h0001 -> next cycle result=16'h0001, with done high on both consecutive cycles.
REQ-020 beq with a=b=16'h1234 -> result=0, zero=1, branch_taken=1. bne with the same operands -> branch_taken=0. jmp with imm=16'h0040 -> result=16'h0040, branch_taken=1.
REQ-021 sll, a=16'h0001, shamt=5 -> busy=1 for 5 cycles, done=1 on the 5th cycle after accept, result=16'h0020. start pulses during busy are ignored. srl with shamt=0 -> done after 1 cycle, result=a.
REQ-022 srl, a=16'h8000, shamt=8; assert rst on the 3rd busy cycle -> busy=0, no done pulse, result=0. A subsequent add completes normally.
REQ-023 alu_ctl=0 and then alu_ctl=15 -> done=1, result=0, illegal=1 each time. A following xor, a=16'h00FF, b=16'h0F0F -> illegal=0, result=16'h0FF0.

Source files
------------

// File: rtl/alu_exec_if.sv
// Request/response bundle for alu_exec. The bench drives the master side and
// alu_exec takes the slave side.
interface alu_exec_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] imm;
    logic [3:0]       shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             branch_taken;
    logic             illegal;

    modport master (
        output start, alu_ctl, op_a, op_b, imm, shamt,
        input  busy, done, result, zero, branch_taken, illegal
    );

    modport slave (
        input  start, alu_ctl, op_a, op_b, imm, shamt,
        output busy, done, result, zero, branch_taken, illegal
    );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU. Most codes complete on the accept edge; sll/srl with a
// non-zero amount walk one bit per cycle in the SHIFT state.
module alu_exec #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    alu_exec_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'd1,  OP_OR   = 4'd2,  OP_SLT  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4,  OP_ADDI = 4'd5,  OP_BEQ  = 4'd6;
    localparam logic [3:0] OP_BNE  = 4'd7,  OP_JMP  = 4'd8,  OP_LW   = 4'd9;
    localparam logic [3:0] OP_SLTI = 4'd10, OP_SLL  = 4'd11, OP_SRL  = 4'd12;
    localparam logic [3:0] OP_SW   = 4'd13, OP_XOR  = 4'd14;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             br_q, br_d;
    logic             ill_q, ill_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             left_q, left_d;

    logic [WIDTH-1:0] op_res;
    logic             op_br;
    logic             op_ill;
    logic             accept;
    logic             multi;
    logic [WIDTH-1:0] sh_next;

    assign accept  = bus.start && (state_q == IDLE);
    // A zero shift amount has nothing to iterate, so it takes the single-cycle path.
    assign multi   = ((bus.alu_ctl == OP_SLL) || (bus.alu_ctl == OP_SRL)) && (bus.shamt != 4'd0);
    assign sh_next = left_q ? (sh_q << 1) : (sh_q >> 1);

    // Single-cycle result, branch decision and legality for the presented code.
    always_comb begin
        op_res = '0;
        op_br  = 1'b0;
        op_ill = 1'b0;
        case (bus.alu_ctl)
            OP_ADD:  op_res = bus.op_a + bus.op_b;
            OP_OR:   op_res = bus.op_a | bus.op_b;
            OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            OP_AND:  op_res = bus.op_a & bus.op_b;
            OP_ADDI: op_res = bus.op_a + bus.imm;
            OP_BEQ:  begin op_res = bus.op_a - bus.op_b; op_br = (bus.op_a == bus.op_b); end
            OP_BNE:  begin op_res = bus.op_a - bus.op_b; op_br = (bus.op_a != bus.op_b); end
            OP_JMP:  begin op_res = bus.imm; op_br = 1'b1; end
            OP_LW:   op_res = bus.op_a + bus.imm;
            OP_SLTI: op_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.imm))};
            OP_SLL:  op_res = bus.op_a << bus.shamt;
            OP_SRL:  op_res = bus.op_a >> bus.shamt;
            OP_SW:   op_res = bus.op_a + bus.imm;
            OP_XOR:  op_res = bus.op_a ^ bus.op_b;
            default: op_ill = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: enter SHIFT for a multi-cycle shift, leave on the last step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && multi) state_d = SHIFT;
            SHIFT:   if (cnt_q == 4'd1)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.busy = (state_q == SHIFT);
    end

    // Datapath next state: capture on accept, step the shifter while in SHIFT.
    always_comb begin
        result_d = result_q;
        br_d     = br_q;
        ill_d    = ill_q;
        done_d   = 1'b0;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        if (accept) begin
            if (multi) begin
                sh_d   = bus.op_a;
                cnt_d  = bus.shamt;
                left_d = (bus.alu_ctl == OP_SLL);
            end else begin
                result_d = op_res;
                br_d     = op_br;
                ill_d    = op_ill;
                done_d   = 1'b1;
            end
        end else if (state_q == SHIFT) begin
            sh_d  = sh_next;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                result_d = sh_next;
                br_d     = 1'b0;
                ill_d    = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    // Datapath registers; reset also aborts an in-flight shift without done.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            br_q     <= 1'b0;
            ill_q    <= 1'b0;
            done_q   <= 1'b0;
            sh_q     <= '0;
            cnt_q    <= 4'd0;
            left_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            br_q     <= br_d;
            ill_q    <= ill_d;
            done_q   <= done_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
        end
    end

    assign bus.done         = done_q;
    assign bus.result       = result_q;
    assign bus.zero         = (result_q == '0);
    assign bus.branch_taken = br_q;
    assign bus.illegal      = ill_q;
endmodule

// File: tb/tb_alu_exec.sv
// Randomised + directed bench for alu_exec with a completion scoreboard.
module tb_alu_exec;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_exec_if #(.WIDTH(16)) bus ();
    alu_exec #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [15:0] res;
        logic        br;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model straight from the code table, using integer arithmetic.
    function automatic exp_t model(input int ctl, input logic [15:0] a, b, im, input int sh);
        exp_t e;
        int   sa, sb_, si;
        sa = int'($signed(a));
        sb_ = int'($signed(b));
        si = int'($signed(im));
        e.br = 1'b0;
        e.ill = 1'b0;
        e.res = 16'h0;
        case (ctl)
            1:  e.res = 16'((int'(a) + int'(b)) % 65536);
            2:  e.res = a | b;
            3:  e.res = (sa < sb_) ? 16'h0001 : 16'h0000;
            4:  e.res = a & b;
            5, 9, 13: e.res = 16'((int'(a) + int'(im)) % 65536);
            6:  begin e.res = 16'((int'(a) + 65536 - int'(b)) % 65536); e.br = (a == b); end
            7:  begin e.res = 16'((int'(a) + 65536 - int'(b)) % 65536); e.br = (a != b); end
            8:  begin e.res = im; e.br = 1'b1; end
            10: e.res = (sa < si) ? 16'h0001 : 16'h0000;
            11: e.res = 16'((int'(a) * (1 << sh)) % 65536);
            12: e.res = 16'(int'(a) / (1 << sh));
            14: e.res = a ^ b;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 32'(bus.result), 32'(e.res));
                chk("zero", 32'(bus.zero), 32'(e.res == 16'h0));
                chk("branch_taken", 32'(bus.branch_taken), 32'(e.br));
                chk("illegal", 32'(bus.illegal), 32'(e.ill));
            end
        end
    end

    task automatic drive(input int ctl, input logic [15:0] a, b, im, input logic [3:0] sh);
        bus.alu_ctl = 4'(ctl);
        bus.op_a    = a;
        bus.op_b    = b;
        bus.imm     = im;
        bus.shamt   = sh;
    endtask

    // Issue one op, optionally spam start with junk while busy, and check timing.
    task automatic run_op(input int ctl, input logic [15:0] a, b, im,
                          input logic [3:0] sh, input bit noise);
        int lat, exp_lat;
        bit seen;
        bit is_multi;
        @(posedge clk); #1;
        drive(ctl, a, b, im, sh);
        bus.start = 1'b1;
        sb.push_back(model(ctl, a, b, im, int'(sh)));
        is_multi = (ctl == 11 || ctl == 12) && sh != 4'd0;
        exp_lat = is_multi ? int'(sh) + 1 : 1;
        @(posedge clk); #1;
        if (noise && is_multi) begin
            drive(int'($urandom_range(1, 10)), 16'($urandom), 16'($urandom),
                  16'($urandom), 4'($urandom));
            bus.start = 1'b1;
        end else begin
            bus.start = 1'b0;
        end
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (bus.done) seen = 1'b1;
            else chk("busy_while_shifting", 32'(bus.busy), 32'(is_multi));
        end
        bus.start = 1'b0;
        if (!seen) chk("done_timeout", 32'(seen), 32'd1);
        else begin
            chk("latency", 32'(lat), 32'(exp_lat));
            chk("busy_at_done", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        drive(0, 16'h0, 16'h0, 16'h0, 4'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_branch", 32'(bus.branch_taken), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);

        // Back-to-back add then slt: done on two consecutive cycles.
        @(posedge clk); #1;
        drive(1, 16'hFFFF, 16'h0002, 16'h0, 4'h0);
        bus.start = 1'b1;
        sb.push_back(model(1, 16'hFFFF, 16'h0002, 16'h0, 0));
        @(posedge clk); #1;
        drive(3, 16'hFFFF, 16'h0001, 16'h0, 4'h0);
        sb.push_back(model(3, 16'hFFFF, 16'h0001, 16'h0, 0));
        @(negedge clk);
        chk("b2b_done_first", 32'(bus.done), 32'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("b2b_done_second", 32'(bus.done), 32'd1);
        @(negedge clk);
        chk("b2b_done_drops", 32'(bus.done), 32'd0);

        // Branches and jump.
        run_op(6, 16'h1234, 16'h1234, 16'h0, 4'h0, 1'b0);
        run_op(7, 16'h1234, 16'h1234, 16'h0, 4'h0, 1'b0);
        run_op(8, 16'h0, 16'h0, 16'h0040, 4'h0, 1'b0);

        // Multi-cycle sll with start spam while busy, zero-amount srl.
        run_op(11, 16'h0001, 16'h0, 16'h0, 4'd5, 1'b1);
        run_op(12, 16'hBEEF, 16'h0, 16'h0, 4'd0, 1'b0);

        // Reset in the third busy cycle of a long srl aborts it silently.
        @(posedge clk); #1;
        drive(12, 16'h8000, 16'h0, 16'h0, 4'd8);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_zero", 32'(bus.zero), 32'd1);
        repeat (8) begin
            @(negedge clk);
            chk("abort_no_done", 32'(bus.done), 32'd0);
        end
        run_op(1, 16'h0010, 16'h0020, 16'h0, 4'h0, 1'b0);

        // Illegal codes, then a legal xor clears illegal.
        run_op(0, 16'h1111, 16'h2222, 16'h3333, 4'h3, 1'b0);
        run_op(15, 16'h1111, 16'h2222, 16'h3333, 4'h3, 1'b0);
        run_op(14, 16'h00FF, 16'h0F0F, 16'h0, 4'h0, 1'b0);

        // Randomised mix over every code.
        for (int k = 0; k < 80; k++) begin
            run_op(int'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                   16'($urandom), 4'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
